// File: rtl/median_ctrl_pkg.sv
// Shared types and tap-offset table for the median frame controller.
package median_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } ctrl_state_t;

    localparam int         TAP_N    = 9;
    localparam logic [3:0] TAP_LAST = 4'(TAP_N - 1);

    // Tap k walks the 3x3 window in raster order: dx = k%3-1, dy = k/3-1.
    function automatic logic signed [1:0] tap_dx(input logic [3:0] tap);
        case (tap)
            4'd0, 4'd3, 4'd6: tap_dx = -2'sd1;
            4'd1, 4'd4, 4'd7: tap_dx = 2'sd0;
            default:          tap_dx = 2'sd1;
        endcase
    endfunction

    function automatic logic signed [1:0] tap_dy(input logic [3:0] tap);
        case (tap)
            4'd0, 4'd1, 4'd2: tap_dy = -2'sd1;
            4'd3, 4'd4, 4'd5: tap_dy = 2'sd0;
            default:          tap_dy = 2'sd1;
        endcase
    endfunction

endpackage

// File: rtl/median_addr_gen.sv
// Maps (x, y, tap) to the source address of that window sample, replicating edge pixels.
module median_addr_gen
    import median_ctrl_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 8,
    parameter int XW     = 4,
    parameter int YW     = 4
) (
    input  logic [XW-1:0]     i_x,
    input  logic [YW-1:0]     i_y,
    input  logic [3:0]        i_tap,
    output logic [ADDR_W-1:0] o_addr
);

    int w_col;
    int w_row;

    always_comb begin
        w_col = int'(i_x) + int'(tap_dx(i_tap));
        w_row = int'(i_y) + int'(tap_dy(i_tap));
        if (w_col < 0)
            w_col = 0;
        else if (w_col > IMG_W - 1)
            w_col = IMG_W - 1;
        if (w_row < 0)
            w_row = 0;
        else if (w_row > IMG_H - 1)
            w_row = IMG_H - 1;
        o_addr = ADDR_W'(w_row * IMG_W + w_col);
    end

endmodule

// File: rtl/median_frame_ctrl.sv
// Raster-order frame sequencer feeding 3x3 windows into the serial median engine
// and writing each result back to the destination RAM.
module median_frame_ctrl
    import median_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int IMG_W   = 16,
    parameter int IMG_H   = 16,
    parameter int ADDR_W  = $clog2(IMG_W * IMG_H),
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              START,
    input  logic              ABORT,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              RD_EN,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [WIDTH-1:0]  RD_DATA,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [WIDTH-1:0]  WR_DATA,
    output logic [WIDTH-1:0]  MED_DI,
    output logic              MED_DSI,
    output logic              MED_nRST,
    input  logic [WIDTH-1:0]  MED_DO,
    input  logic              MED_DSO,
    output logic [1:0]        o_dbg_state
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(TIMEOUT + 1);

    ctrl_state_t       r_state;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [3:0]        r_tap;
    logic [CW-1:0]     r_wait_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_rd_en;
    logic              r_dsi;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WIDTH-1:0]  r_wr_data;
    logic              r_flush;

    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_pix_addr;
    logic              w_last_x;
    logic              w_last_pix;

    median_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W),
        .XW    (XW),
        .YW    (YW)
    ) u_addr_gen (
        .i_x   (r_x),
        .i_y   (r_y),
        .i_tap (r_tap),
        .o_addr(w_rd_addr)
    );

    assign w_pix_addr = ADDR_W'(int'(r_y) * IMG_W + int'(r_x));
    assign w_last_x   = (r_x == XW'(IMG_W - 1));
    assign w_last_pix = w_last_x && (r_y == YW'(IMG_H - 1));

    // ABORT outranks everything but reset; it also drops a coincident START.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_tap      <= '0;
            r_wait_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_en    <= 1'b0;
            r_dsi      <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_flush    <= 1'b0;
        end else begin
            r_dsi   <= r_rd_en;
            r_done  <= 1'b0;
            r_flush <= 1'b0;
            r_wr_en <= 1'b0;
            if (ABORT) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_rd_en <= 1'b0;
                r_dsi   <= 1'b0;
                r_flush <= 1'b1;
                r_x     <= '0;
                r_y     <= '0;
                r_tap   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (START) begin
                            r_state <= FETCH;
                            r_x     <= '0;
                            r_y     <= '0;
                            r_tap   <= '0;
                            r_err   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_rd_en <= 1'b1;
                        end
                    end
                    FETCH: begin
                        if (r_tap == TAP_LAST) begin
                            r_state    <= WAIT;
                            r_rd_en    <= 1'b0;
                            r_wait_cnt <= '0;
                        end else begin
                            r_tap <= r_tap + 4'd1;
                        end
                    end
                    WAIT: begin
                        if (MED_DSO) begin
                            r_state   <= WRITE;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_pix_addr;
                            r_wr_data <= MED_DO;
                        end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
                            r_state <= IDLE;
                            r_err   <= 1'b1;
                            r_flush <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                    WRITE: begin
                        r_tap <= '0;
                        if (w_last_pix) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_x     <= '0;
                            r_y     <= '0;
                        end else begin
                            r_state <= FETCH;
                            r_rd_en <= 1'b1;
                            if (w_last_x) begin
                                r_x <= '0;
                                r_y <= r_y + 1'b1;
                            end else begin
                                r_x <= r_x + 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign ERR         = r_err;
    assign RD_EN       = r_rd_en;
    assign RD_ADDR     = w_rd_addr;
    assign WR_EN       = r_wr_en;
    assign WR_ADDR     = r_wr_addr;
    assign WR_DATA     = r_wr_data;
    assign MED_DI      = RD_DATA;
    assign MED_DSI     = r_dsi;
    assign MED_nRST    = nRST & ~r_flush;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Directed-plus-random bench for median_frame_ctrl on a 4x4 image with behavioural RAMs and engine.
module tb_median_frame_ctrl;
    import median_ctrl_pkg::*;

    localparam int WIDTH   = 8;
    localparam int IMG_W   = 4;
    localparam int IMG_H   = 4;
    localparam int NPIX    = IMG_W * IMG_H;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 16;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              START = 1'b0;
    logic              ABORT = 1'b0;
    logic              BUSY, DONE, ERR, RD_EN, WR_EN, MED_DSI, MED_nRST;
    logic [ADDR_W-1:0] RD_ADDR, WR_ADDR;
    logic [WIDTH-1:0]  RD_DATA, WR_DATA, MED_DI, MED_DO;
    logic              MED_DSO;
    logic [1:0]        o_dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    median_frame_ctrl #(
        .WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .nRST(nRST), .START(START), .ABORT(ABORT),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .MED_DI(MED_DI), .MED_DSI(MED_DSI), .MED_nRST(MED_nRST),
        .MED_DO(MED_DO), .MED_DSO(MED_DSO), .o_dbg_state(o_dbg_state)
    );

    // Behavioural source RAM with one-cycle read latency.
    logic [WIDTH-1:0] src_mem [NPIX];
    initial RD_DATA = '0;
    always @(posedge CLK) if (RD_EN) RD_DATA <= src_mem[RD_ADDR];

    function automatic logic [WIDTH-1:0] median9(input logic [WIDTH-1:0] v [9]);
        logic [WIDTH-1:0] s [9];
        logic [WIDTH-1:0] t;
        s = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        return s[4];
    endfunction

    // Stand-in median engine: collects 9 strobed samples, answers after a random delay.
    logic [WIDTH-1:0] eng_win [9];
    int               eng_n = 0;
    int               eng_cnt = 0;
    logic [WIDTH-1:0] eng_res = '0;
    bit               eng_stall = 1'b0;
    initial begin MED_DSO = 1'b0; MED_DO = '0; end
    always @(posedge CLK) begin
        MED_DSO <= 1'b0;
        if (!MED_nRST) begin
            eng_n = 0;
            eng_cnt = 0;
        end else if (MED_DSI) begin
            eng_win[eng_n] = MED_DI;
            eng_n++;
            if (eng_n == 9) begin
                eng_res = median9(eng_win);
                eng_n = 0;
                eng_cnt = $urandom_range(1, 6);
            end
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0 && !eng_stall) begin
                MED_DSO <= 1'b1;
                MED_DO  <= eng_res;
            end
        end
    end

    // Destination RAM write log and DONE counter.
    logic [ADDR_W-1:0] obs_addr_q [$];
    logic [WIDTH-1:0]  obs_data_q [$];
    int                done_cnt = 0;
    always @(negedge CLK) begin
        if (WR_EN) begin
            obs_addr_q.push_back(WR_ADDR);
            obs_data_q.push_back(WR_DATA);
        end
        if (DONE) done_cnt++;
    end

    // Reference model: clamped 3x3 median of the whole image, raster order.
    logic [WIDTH-1:0] exp_q [$];

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic int win_addr(input int x, input int y, input int k);
        return clampi(y + k / 3 - 1, IMG_H - 1) * IMG_W + clampi(x + k % 3 - 1, IMG_W - 1);
    endfunction

    task automatic build_expected();
        logic [WIDTH-1:0] w [9];
        exp_q.delete();
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) begin
                for (int k = 0; k < 9; k++) w[k] = src_mem[win_addr(x, y, k)];
                exp_q.push_back(median9(w));
            end
    endtask

    task automatic load_image(input int kind);
        for (int a = 0; a < NPIX; a++)
            case (kind)
                0:       src_mem[a] = 8'h55;
                1:       src_mem[a] = (a == 5) ? 8'hFF : 8'h00;
                2:       src_mem[a] = 8'(a);
                default: src_mem[a] = 8'($urandom_range(0, 255));
            endcase
        build_expected();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    task automatic wait_rd_low(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!RD_EN) begin seen = 1'b1; break; end
            tick(1);
        end
        chk({tag, "_wait_entry"}, 32'(seen), 32'd1);
    endtask

    task automatic finish_frame(input string tag, input int w0, input int d0);
        bit seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (DONE) begin seen = 1'b1; break; end
            tick(1);
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
        tick(1);
        chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
        chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
        chk({tag, "_err"}, 32'(ERR), 32'd0);
        chk({tag, "_n_writes"}, 32'(obs_addr_q.size() - w0), 32'(NPIX));
        for (int i = 0; i < NPIX; i++)
            if (w0 + i < obs_addr_q.size()) begin
                chk({tag, "_wr_addr"}, 32'(obs_addr_q[w0+i]), 32'(i));
                chk({tag, "_wr_data"}, 32'(obs_data_q[w0+i]), 32'(exp_q[i]));
            end
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int w0, d0, k, wc;
        bit seen;

        // Reset state
        tick(3);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_rd_en", 32'(RD_EN), 32'd0);
        chk("rst_wr_en", 32'(WR_EN), 32'd0);
        chk("rst_dsi", 32'(MED_DSI), 32'd0);
        chk("rst_med_nrst", 32'(MED_nRST), 32'd0);
        chk("rst_state", 32'(o_dbg_state), 32'(IDLE));
        nRST = 1'b1;
        tick(1);
        chk("post_rst_med_nrst", 32'(MED_nRST), 32'd1);

        // Constant image, with the first window's address and strobe pattern checked
        load_image(0);
        w0 = obs_addr_q.size(); d0 = done_cnt;
        pulse_start();
        chk("c55_busy", 32'(BUSY), 32'd1);
        for (int t = 0; t < 9; t++) begin
            chk("win0_rd_en", 32'(RD_EN), 32'd1);
            chk("win0_rd_addr", 32'(RD_ADDR), 32'(win_addr(0, 0, t)));
            chk("win0_dsi", 32'(MED_DSI), (t == 0) ? 32'd0 : 32'd1);
            tick(1);
        end
        chk("win0_rd_en_off", 32'(RD_EN), 32'd0);
        chk("win0_dsi_last", 32'(MED_DSI), 32'd1);
        tick(1);
        chk("win0_dsi_off", 32'(MED_DSI), 32'd0);
        finish_frame("c55", w0, d0);

        // Single bright pixel is filtered out; ramp keeps its interior values
        load_image(1);
        w0 = obs_addr_q.size(); d0 = done_cnt;
        pulse_start();
        finish_frame("spike", w0, d0);
        load_image(2);
        w0 = obs_addr_q.size(); d0 = done_cnt;
        pulse_start();
        finish_frame("ramp", w0, d0);
        chk("ramp_px5", 32'(obs_data_q[w0+5]), 32'd5);

        // Random image with stray STARTs while busy
        load_image(3);
        w0 = obs_addr_q.size(); d0 = done_cnt;
        pulse_start();
        for (int s = 0; s < 3; s++) begin
            tick($urandom_range(5, 50));
            pulse_start();
        end
        finish_frame("rand_stray_start", w0, d0);

        // Engine never answers: timeout after TIMEOUT wait cycles
        eng_stall = 1'b1;
        load_image(3);
        w0 = obs_addr_q.size(); d0 = done_cnt;
        pulse_start();
        wait_rd_low("tmo");
        wc = 0;
        for (int c = 0; c < 100; c++) begin
            if (ERR) break;
            wc++;
            tick(1);
        end
        chk("tmo_wait_cycles", 32'(wc), 32'(TIMEOUT));
        chk("tmo_err", 32'(ERR), 32'd1);
        chk("tmo_flush", 32'(MED_nRST), 32'd0);
        chk("tmo_busy", 32'(BUSY), 32'd0);
        tick(1);
        chk("tmo_flush_end", 32'(MED_nRST), 32'd1);
        chk("tmo_err_sticky", 32'(ERR), 32'd1);
        tick(5);
        chk("tmo_no_write", 32'(obs_addr_q.size() - w0), 32'd0);
        chk("tmo_no_done", 32'(done_cnt - d0), 32'd0);
        eng_stall = 1'b0;
        pulse_start();
        chk("tmo_err_clear", 32'(ERR), 32'd0);
        finish_frame("after_tmo", w0, d0);

        // ABORT at tap 4 of pixel 6
        load_image(3);
        w0 = obs_addr_q.size(); d0 = done_cnt;
        pulse_start();
        k = 0;
        for (int c = 0; c < 1000; c++) begin
            if (obs_addr_q.size() - w0 == 6 && RD_EN) begin
                k++;
                if (k == 5) break;
            end
            tick(1);
        end
        chk("abort_reach_tap4", 32'(k), 32'd5);
        chk("abort_tap4_addr", 32'(RD_ADDR), 32'(win_addr(2, 1, 4)));
        ABORT = 1'b1;
        tick(1);
        ABORT = 1'b0;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_rd_en", 32'(RD_EN), 32'd0);
        chk("abort_dsi", 32'(MED_DSI), 32'd0);
        chk("abort_flush", 32'(MED_nRST), 32'd0);
        tick(1);
        chk("abort_flush_end", 32'(MED_nRST), 32'd1);
        tick(30);
        chk("abort_writes", 32'(obs_addr_q.size() - w0), 32'd6);
        for (int i = 0; i < 6; i++)
            chk("abort_wr_data", 32'(obs_data_q[w0+i]), 32'(exp_q[i]));
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_idle", 32'(BUSY), 32'd0);
        w0 = obs_addr_q.size();
        pulse_start();
        chk("restart_rd_en", 32'(RD_EN), 32'd1);
        chk("restart_rd_addr", 32'(RD_ADDR), 32'd0);
        finish_frame("restart", w0, d0);

        // ABORT and START together in IDLE: flush only
        ABORT = 1'b1; START = 1'b1;
        tick(1);
        ABORT = 1'b0; START = 1'b0;
        chk("abst_busy", 32'(BUSY), 32'd0);
        chk("abst_rd_en", 32'(RD_EN), 32'd0);
        chk("abst_flush", 32'(MED_nRST), 32'd0);
        tick(1);
        chk("abst_flush_end", 32'(MED_nRST), 32'd1);
        chk("abst_busy2", 32'(BUSY), 32'd0);

        // nRST during WAIT loses the frame
        load_image(3);
        w0 = obs_addr_q.size(); d0 = done_cnt;
        pulse_start();
        wait_rd_low("rstw");
        nRST = 1'b0;
        tick(1);
        chk("rstw_busy", 32'(BUSY), 32'd0);
        chk("rstw_rd_en", 32'(RD_EN), 32'd0);
        chk("rstw_wr_en", 32'(WR_EN), 32'd0);
        chk("rstw_dsi", 32'(MED_DSI), 32'd0);
        chk("rstw_err", 32'(ERR), 32'd0);
        chk("rstw_med_nrst", 32'(MED_nRST), 32'd0);
        nRST = 1'b1;
        tick(40);
        chk("rstw_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rstw_no_write", 32'(obs_addr_q.size() - w0), 32'd0);
        chk("rstw_idle", 32'(BUSY), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
